mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 64x8 memory array.
- Requester 0 is the GPIO (mprj_io) side; requester 1 is the logic-analyzer/firmware side.
- Serialises read/write transactions onto the single memory port with round-robin fairness and a fixed read latency.
- Returns a one-cycle ack and, for reads, the read data to the winning requester.

Parameters:
- ADDR_W, 6, memory address width (64 entries).
- DATA_W, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..3.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- rq0_req  in  1  requester 0 transaction request; held high until rq0_ack.
- rq0_we  in  1  1 = write, 0 = read; stable while rq0_req is high.
- rq0_addr  in  ADDR_W  requester 0 address.
- rq0_wdata  in  DATA_W  requester 0 write data.
- rq0_ack  out  1  one-cycle completion pulse.
- rq0_rdata  out  DATA_W  read data; valid in the rq0_ack cycle and held until the next rq0 read completes.
- rq1_req, rq1_we, rq1_addr, rq1_wdata, rq1_ack, rq1_rdata: same as rq0_*, for requester 1.
- rq1_err  out  1  pulses with rq1_ack when a write is rejected (optional feature only).
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset:
  - Asserting resetb low clears all outputs to 0, the state to IDLE and the priority pointer to 0 (requester 0 favoured).
  - Reset is asynchronous and takes effect mid-transaction: mem_en drops immediately, the in-flight transaction is discarded and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester named by the pointer.
  - Latch we/addr/wdata and the grant id, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1, with mem_we/mem_addr/mem_wdata taken from the latched copy.
  - Write: next state is DONE.
  - Read: next state is WAIT, with the latency counter loaded to RD_LAT-1.
- WAIT:
  - Count down.
  - When the count is 0, register mem_rdata into the granted rqX_rdata and go to DONE.
  - With RD_LAT=1, WAIT lasts exactly 1 cycle.
- DONE (1 cycle):
  - Pulse rqX_ack=1 for the granted requester only.
  - Toggle the pointer to the other requester.
  - Return to IDLE.
- Latency:
  - Write: mem_en is high 1 cycle after req is sampled; ack comes 2 cycles after req is sampled.
  - Read: ack comes 2+RD_LAT cycles after req is sampled.
  - Minimum spacing between mem_en pulses is 3 cycles (write) or 3+RD_LAT cycles (read).
- Arbitration is evaluated only in IDLE.
  - A req rising in any other state waits; it is never dropped.
  - A requester whose req is still high in the DONE cycle is treated as a new request at the next IDLE.
- Round-robin: both requesting continuously gives alternating grants 0,1,0,1...
- Requester inputs are latched in IDLE; changes during ISSUE/WAIT/DONE have no effect.
- mem_we, mem_addr and mem_wdata hold their last values when mem_en=0.
- rqX_rdata of the non-granted requester is never modified.

Optional Feature:
- Macro: MEM_ARB_WPROT_EN.
- Defined:
  - A requester-1 write to an address with MSB=1 (0x20..0x3F) is rejected.
  - The FSM goes ISSUE→DONE with mem_en held 0.
  - rq1_ack and rq1_err pulse together; the pointer still toggles.
  - Requester-1 reads and all requester-0 accesses are unaffected.
- Undefined: rq1_err is tied to 0 and every write is issued.

Test Plan:
- Write then read, RD_LAT=1:
  - rq0 write addr 0x39 data 0xFA → mem_en/mem_we=1 at cycle+1, rq0_ack at cycle+2.
  - rq0 read addr 0x39 → rq0_rdata=0xFA with ack at cycle+3.
- Contention: rq0 and rq1 both raise write requests in the same cycle from reset → rq0 is served first (addr 0x18, data 0xEA), rq1 second; with both held, grants alternate 0,1,0,1 over 4 transactions.
- RD_LAT=3: rq1 read addr 0x05 → exactly 1 mem_en pulse, ack 5 cycles after request; rq0_rdata unchanged.
- Reset mid-read: resetb low during WAIT → mem_en=0 and all acks 0 immediately; after release, state is IDLE and pointer is 0, and a fresh rq1 read completes normally.
- Late request: rq1_req rises during rq0's ISSUE → rq1 is granted at the next IDLE and is not lost.
- MEM_ARB_WPROT_EN defined: rq1 write 0x2A → no mem_en, rq1_ack=rq1_err=1; a follow-up read of 0x2A returns the old data. Undefined: the write is issued and rq1_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port 64x8 memory.
// Build option MEM_ARB_WPROT_EN: reject requester-1 writes to the upper address half.
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              rq0_req,
    input  logic              rq0_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    output logic [DATA_W-1:0] rq0_rdata,
    input  logic              rq1_req,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            r_state;
    logic              r_ptr;
    logic              r_gnt;
    logic              r_we;
    logic [1:0]        r_cnt;

    logic              w_gnt;
    logic              w_we;
    logic              w_reject;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Pointer only matters when both requesters compete.
    always_comb begin
        w_gnt   = (rq0_req && rq1_req) ? r_ptr : rq1_req;
        w_we    = w_gnt ? rq1_we    : rq0_we;
        w_addr  = w_gnt ? rq1_addr  : rq0_addr;
        w_wdata = w_gnt ? rq1_wdata : rq0_wdata;
    end

`ifdef MEM_ARB_WPROT_EN
    logic r_rej;

    assign w_reject = w_gnt & w_we & w_addr[ADDR_W-1];

    // A rejected write is always ISSUE->DONE, so the error lines up with rq1_ack.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rej   <= 1'b0;
            rq1_err <= 1'b0;
        end else begin
            rq1_err <= (r_state == ISSUE) && r_rej;
            if (r_state == IDLE)
                r_rej <= w_reject;
        end
    end
`else
    assign w_reject = 1'b0;
    assign rq1_err  = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_gnt     <= 1'b0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            rq0_ack   <= 1'b0;
            rq1_ack   <= 1'b0;
            rq0_rdata <= '0;
            rq1_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rq0_ack <= 1'b0;
            rq1_ack <= 1'b0;
            mem_en  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rq0_req || rq1_req) begin
                        r_gnt   <= w_gnt;
                        r_we    <= w_we;
                        r_state <= ISSUE;
                        // The memory-side registers double as the latched request copy.
                        if (!w_reject) begin
                            mem_en    <= 1'b1;
                            mem_we    <= w_we;
                            mem_addr  <= w_addr;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state <= DONE;
                        rq0_ack <= ~r_gnt;
                        rq1_ack <= r_gnt;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= 2'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= DONE;
                        rq0_ack <= ~r_gnt;
                        rq1_ack <= r_gnt;
                        if (r_gnt)
                            rq1_rdata <= mem_rdata;
                        else
                            rq0_rdata <= mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                DONE: begin
                    r_ptr   <= ~r_gnt;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 and RD_LAT=3 instances against a transaction-level model.
// Follows MEM_ARB_WPROT_EN when the bench is built with it.
module tb_mem_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clock;
    logic          resetb;
    logic          sel;
    logic          rq0_req, rq0_we, rq1_req, rq1_we;
    logic [AW-1:0] rq0_addr, rq1_addr;
    logic [DW-1:0] rq0_wdata, rq1_wdata;

    logic          d_req0 [2];
    logic          d_req1 [2];
    logic          d_ack0 [2];
    logic          d_ack1 [2];
    logic          d_err  [2];
    logic          d_en   [2];
    logic          d_we   [2];
    logic [AW-1:0] d_addr [2];
    logic [DW-1:0] d_wdata[2];
    logic [DW-1:0] d_rdata[2];
    logic [DW-1:0] d_rd0  [2];
    logic [DW-1:0] d_rd1  [2];

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign d_req0[0] = rq0_req & ~sel;
    assign d_req1[0] = rq1_req & ~sel;
    assign d_req0[1] = rq0_req & sel;
    assign d_req1[1] = rq1_req & sel;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_lat1 (
        .clock(clock), .resetb(resetb),
        .rq0_req(d_req0[0]), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ack(d_ack0[0]), .rq0_rdata(d_rd0[0]),
        .rq1_req(d_req1[0]), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ack(d_ack1[0]), .rq1_rdata(d_rd1[0]), .rq1_err(d_err[0]),
        .mem_en(d_en[0]), .mem_we(d_we[0]), .mem_addr(d_addr[0]), .mem_wdata(d_wdata[0]),
        .mem_rdata(d_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_lat3 (
        .clock(clock), .resetb(resetb),
        .rq0_req(d_req0[1]), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ack(d_ack0[1]), .rq0_rdata(d_rd0[1]),
        .rq1_req(d_req1[1]), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ack(d_ack1[1]), .rq1_rdata(d_rd1[1]), .rq1_err(d_err[1]),
        .mem_en(d_en[1]), .mem_we(d_we[1]), .mem_addr(d_addr[1]), .mem_wdata(d_wdata[1]),
        .mem_rdata(d_rdata[1])
    );

    // Observed outputs of the currently selected instance.
    logic          o_en, o_we, o_ack0, o_ack1, o_err;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rd0, o_rd1;
    assign o_en    = d_en[sel];
    assign o_we    = d_we[sel];
    assign o_addr  = d_addr[sel];
    assign o_wdata = d_wdata[sel];
    assign o_ack0  = d_ack0[sel];
    assign o_ack1  = d_ack1[sel];
    assign o_err   = d_err[sel];
    assign o_rd0   = d_rd0[sel];
    assign o_rd1   = d_rd1[sel];

    function automatic logic [7:0] init_val(int k, int a);
        return 8'((a * 29 + 7 + k * 101) % 256);
    endfunction

    // Memory models: data leaves stage 0 one cycle after mem_en, then one stage per extra cycle.
    logic [DW-1:0] mem  [2][64];
    logic [DW-1:0] pipe [2][3];
    assign d_rdata[0] = pipe[0][0];
    assign d_rdata[1] = pipe[1][2];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetb) begin
                for (int a = 0; a < 64; a++) mem[k][a] <= init_val(k, a);
            end else if (d_en[k] && d_we[k]) begin
                mem[k][d_addr[k]] <= d_wdata[k];
            end
            pipe[k][0] <= (d_en[k] && !d_we[k]) ? mem[k][d_addr[k]] : 8'($urandom);
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end

    // Reference state per instance.
    logic [7:0]    ref_mem [2][64];
    logic          mptr    [2];
    logic [7:0]    mrd     [2][2];
    logic          hold_we [2];
    logic [AW-1:0] hold_addr [2];
    logic [DW-1:0] hold_wdata[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) ref_mem[k][a] = init_val(k, a);
            mptr[k] = 1'b0;
            mrd[k][0] = '0;
            mrd[k][1] = '0;
            hold_we[k] = 1'b0;
            hold_addr[k] = '0;
            hold_wdata[k] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One scenario: each requester optionally raises one request at cycle st0/st1 and holds it to its ack.
    task automatic scen(input logic s,
                        input logic v0, input int st0, input logic we0, input logic [5:0] a0, input logic [7:0] wd0,
                        input logic v1, input int st1, input logic we1, input logic [5:0] a1, input logic [7:0] wd1);
        int lat, t, e, w, d, last;
        logic rej;
        logic pend [2];
        int start [2];
        logic wev [2];
        logic [5:0] av [2];
        logic [7:0] dv [2];
        logic e_en [32];
        logic e_we [32];
        logic [5:0] e_addr [32];
        logic [7:0] e_wd [32];
        logic e_ack [2][32];
        logic e_err [32];
        logic e_isrd [2][32];
        logic [7:0] e_rdv [2][32];

        sel = s;
        lat = s ? 3 : 1;
        pend[0] = v0; start[0] = st0; wev[0] = we0; av[0] = a0; dv[0] = wd0;
        pend[1] = v1; start[1] = st1; wev[1] = we1; av[1] = a1; dv[1] = wd1;
        for (int c = 0; c < 32; c++) begin
            e_en[c] = 1'b0; e_we[c] = 1'b0; e_addr[c] = '0; e_wd[c] = '0; e_err[c] = 1'b0;
            e_ack[0][c] = 1'b0; e_ack[1][c] = 1'b0;
            e_isrd[0][c] = 1'b0; e_isrd[1][c] = 1'b0;
            e_rdv[0][c] = '0; e_rdv[1][c] = '0;
        end

        t = 0;
        last = 0;
        while (pend[0] || pend[1]) begin
            e = 1000;
            for (int r = 0; r < 2; r++) if (pend[r] && start[r] < e) e = start[r];
            if (e < t) e = t;
            if (pend[0] && pend[1] && start[0] <= e && start[1] <= e) w = mptr[s] ? 1 : 0;
            else w = (pend[1] && start[1] <= e) ? 1 : 0;
            rej = 1'b0;
`ifdef MEM_ARB_WPROT_EN
            rej = (w == 1) && wev[1] && av[1][5];
`endif
            if (!rej) begin
                e_en[e+1] = 1'b1; e_we[e+1] = wev[w]; e_addr[e+1] = av[w]; e_wd[e+1] = dv[w];
            end
            d = e + (wev[w] ? 2 : 2 + lat);
            e_ack[w][d] = 1'b1;
            e_err[d] = rej;
            if (!wev[w]) begin
                e_isrd[w][d] = 1'b1;
                e_rdv[w][d] = ref_mem[s][av[w]];
            end else if (!rej) begin
                ref_mem[s][av[w]] = dv[w];
            end
            mptr[s] = (w == 0);
            t = d + 1;
            pend[w] = 1'b0;
            last = d;
        end

        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clock);
            if (e_en[c]) begin
                hold_we[s] = e_we[c]; hold_addr[s] = e_addr[c]; hold_wdata[s] = e_wd[c];
            end
            for (int r = 0; r < 2; r++) if (e_isrd[r][c]) mrd[s][r] = e_rdv[r][c];
            check("mem_en", 32'(o_en), 32'(e_en[c]));
            check("mem_we", 32'(o_we), 32'(hold_we[s]));
            check("mem_addr", 32'(o_addr), 32'(hold_addr[s]));
            check("mem_wdata", 32'(o_wdata), 32'(hold_wdata[s]));
            check("rq0_ack", 32'(o_ack0), 32'(e_ack[0][c]));
            check("rq1_ack", 32'(o_ack1), 32'(e_ack[1][c]));
            check("rq1_err", 32'(o_err), 32'(e_err[c]));
            check("rq0_rdata", 32'(o_rd0), 32'(mrd[s][0]));
            check("rq1_rdata", 32'(o_rd1), 32'(mrd[s][1]));

            if (rq0_req && o_ack0) rq0_req = 1'b0;
            if (!rq0_req) begin
                if (v0 && c == st0) begin
                    rq0_req = 1'b1; rq0_we = we0; rq0_addr = a0; rq0_wdata = wd0;
                end else begin
                    rq0_we = 1'($urandom); rq0_addr = 6'($urandom); rq0_wdata = 8'($urandom);
                end
            end
            if (rq1_req && o_ack1) rq1_req = 1'b0;
            if (!rq1_req) begin
                if (v1 && c == st1) begin
                    rq1_req = 1'b1; rq1_we = we1; rq1_addr = a1; rq1_wdata = wd1;
                end else begin
                    rq1_we = 1'($urandom); rq1_addr = 6'($urandom); rq1_wdata = 8'($urandom);
                end
            end
        end
        rq0_req = 1'b0;
        rq1_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_en", 32'(o_en), 32'd0);
        check("rst_mem_we", 32'(o_we), 32'd0);
        check("rst_mem_addr", 32'(o_addr), 32'd0);
        check("rst_mem_wdata", 32'(o_wdata), 32'd0);
        check("rst_rq0_ack", 32'(o_ack0), 32'd0);
        check("rst_rq1_ack", 32'(o_ack1), 32'd0);
        check("rst_rq1_err", 32'(o_err), 32'd0);
        check("rst_rq0_rdata", 32'(o_rd0), 32'd0);
        check("rst_rq1_rdata", 32'(o_rd1), 32'd0);
    endtask

    initial begin
        logic rv0, rv1;
        resetb = 1'b0;
        sel = 1'b0;
        rq0_req = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
        rq1_req = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
        model_reset();
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check_reset_outputs();
        end
        sel = 1'b0;
        @(negedge clock);
        resetb = 1'b1;

        // Contention from reset: two rounds with both raising together.
        scen(1'b0, 1'b1, 0, 1'b1, 6'h18, 8'hEA, 1'b1, 0, 1'b1, 6'h07, 8'h5C);
        scen(1'b0, 1'b1, 0, 1'b1, 6'h19, 8'h3B, 1'b1, 0, 1'b0, 6'h18, 8'h00);
        // Write then read back.
        scen(1'b0, 1'b1, 0, 1'b1, 6'h39, 8'hFA, 1'b0, 0, 1'b0, 6'h00, 8'h00);
        scen(1'b0, 1'b1, 0, 1'b0, 6'h39, 8'h00, 1'b0, 0, 1'b0, 6'h00, 8'h00);
        // Long read latency instance.
        scen(1'b1, 1'b0, 0, 1'b0, 6'h00, 8'h00, 1'b1, 0, 1'b0, 6'h05, 8'h00);
        // Late request during rq0's ISSUE.
        scen(1'b0, 1'b1, 0, 1'b1, 6'h0C, 8'h41, 1'b1, 1, 1'b0, 6'h39, 8'h00);
        // Requester-1 upper-half write, then read it back.
        scen(1'b0, 1'b0, 0, 1'b0, 6'h00, 8'h00, 1'b1, 0, 1'b1, 6'h2A, 8'h77);
        scen(1'b0, 1'b0, 0, 1'b0, 6'h00, 8'h00, 1'b1, 0, 1'b0, 6'h2A, 8'h00);

        // Reset asserted while the RD_LAT=3 instance is waiting on read data.
        sel = 1'b1;
        @(negedge clock);
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 6'h11;
        @(negedge clock);
        check("midrst_issue_en", 32'(o_en), 32'd1);
        @(negedge clock);
        check("midrst_wait_en", 32'(o_en), 32'd0);
        resetb = 1'b0;
        #1;
        check_reset_outputs();
        rq0_req = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        model_reset();
        scen(1'b1, 1'b0, 0, 1'b0, 6'h00, 8'h00, 1'b1, 0, 1'b0, 6'h11, 8'h00);
        scen(1'b1, 1'b1, 0, 1'b1, 6'h22, 8'h99, 1'b1, 0, 1'b1, 6'h03, 8'h66);

        for (int n = 0; n < 60; n++) begin
            rv0 = 1'($urandom);
            rv1 = rv0 ? 1'($urandom) : 1'b1;
            scen(1'($urandom),
                 rv0, int'($urandom_range(0, 3)), 1'($urandom), {1'($urandom), 2'b00, 3'($urandom)}, 8'($urandom),
                 rv1, int'($urandom_range(0, 3)), 1'($urandom), {1'($urandom), 2'b00, 3'($urandom)}, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
